// File: rtl/cdu_counter_bank.sv
// ---------------------------------------------------------------------------
// cdu_counter_bank
//
// Multi-channel CDU counter-increment interface. Each gimbal channel collects
// fine up/down pulses into a signed, saturating pending count. Pending counts
// are drained to the computer one increment at a time as PCDU (+1) or MCDU (-1)
// requests over a req/ack handshake. Grants are paced by rate_strobe (at most
// one per strobe) and arbitrated round-robin starting after the last channel
// that was acknowledged. Each channel also keeps a local angle read counter
// that follows every acknowledged increment.
//
// Ports
//   CLOCKH       system clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   up_pulse     per-channel one-cycle +1 increment request
//   dn_pulse     per-channel one-cycle -1 increment request
//   zero         per-channel level: holds pending, angle and overflow at 0
//   rate_strobe  one-cycle pacing strobe, only honoured while idle
//   req_valid    increment request to the computer
//   req_chan     channel index of the current request
//   req_dir      1 = PCDU (+1), 0 = MCDU (-1)
//   req_ack      computer accepted the request (ignored while req_valid=0)
//   angle        concatenated angle counters, channel 0 in the LSBs
//   overflow     per-channel sticky flag: pending accumulator saturated
// ---------------------------------------------------------------------------
module cdu_counter_bank #(
    parameter int CHANNELS = 3,
    parameter int PEND_W   = 6,
    parameter int ANGLE_W  = 16,
    parameter int CH_W     = 3
) (
    input  logic                        CLOCKH,
    input  logic                        rst_n,
    input  logic [CHANNELS-1:0]         up_pulse,
    input  logic [CHANNELS-1:0]         dn_pulse,
    input  logic [CHANNELS-1:0]         zero,
    input  logic                        rate_strobe,
    output logic                        req_valid,
    output logic [CH_W-1:0]             req_chan,
    output logic                        req_dir,
    input  logic                        req_ack,
    output logic [CHANNELS*ANGLE_W-1:0] angle,
    output logic [CHANNELS-1:0]         overflow
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    // Pending arithmetic is done two bits wider than the accumulator so that
    // +1 input and -1 drain can both be applied before the clamp is decided.
    localparam int SUM_W = PEND_W + 2;
    localparam logic signed [SUM_W-1:0] SAT_HI  = {3'b000, {(PEND_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_LO  = -SAT_HI;
    localparam logic signed [SUM_W-1:0] SUM_ONE = {{(SUM_W-1){1'b0}}, 1'b1};
    localparam logic [ANGLE_W-1:0]      ANG_ONE = {{(ANGLE_W-1){1'b0}}, 1'b1};

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e                     state_q,      state_d;
    logic [CH_W-1:0]            req_chan_q,   req_chan_d;
    logic                       req_dir_q,    req_dir_d;
    logic [CH_W-1:0]            last_grant_q, last_grant_d;
    logic signed [PEND_W-1:0]   pending_q  [CHANNELS];
    logic signed [PEND_W-1:0]   pending_d  [CHANNELS];
    logic [ANGLE_W-1:0]         angle_q    [CHANNELS];
    logic [ANGLE_W-1:0]         angle_d    [CHANNELS];
    logic [CHANNELS-1:0]        overflow_q, overflow_d;

    // -----------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------
    logic [CHANNELS-1:0] chan_hit;     // one-hot of req_chan_q
    logic                zero_on_req;  // in-flight channel is being zeroed
    logic                ack_take;     // acknowledge that actually takes effect

    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves a signal unassigned would infer a latch.
        chan_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            chan_hit[i] = (req_chan_q == CH_W'(i));
        end
        zero_on_req = (state_q == ST_REQ) && ((zero & chan_hit) != '0);
        // A zero on the in-flight channel withdraws the request, so an ack in
        // the same cycle must not move the angle or the grant pointer.
        ack_take    = (state_q == ST_REQ) && req_ack && !zero_on_req;
    end

    // -----------------------------------------------------------------------
    // Per-channel pending accumulator, angle counter and overflow flag
    // -----------------------------------------------------------------------
    always_comb begin
        logic signed [SUM_W-1:0] sum;
        sum        = '0;
        overflow_d = overflow_q;
        for (int i = 0; i < CHANNELS; i++) begin
            pending_d[i] = pending_q[i];
            angle_d[i]   = angle_q[i];

            if (zero[i]) begin
                pending_d[i]  = '0;
                angle_d[i]    = '0;
                overflow_d[i] = 1'b0;
            end else begin
                sum = {{2{pending_q[i][PEND_W-1]}}, pending_q[i]};

                // Simultaneous up and dn cancel.
                if (up_pulse[i] && !dn_pulse[i]) begin
                    sum = sum + SUM_ONE;
                end else if (dn_pulse[i] && !up_pulse[i]) begin
                    sum = sum - SUM_ONE;
                end

                // The drain follows the direction latched at grant time, even
                // if opposing pulses flipped the sign of pending since then.
                if (ack_take && chan_hit[i]) begin
                    if (req_dir_q) begin
                        sum        = sum - SUM_ONE;
                        angle_d[i] = angle_q[i] + ANG_ONE;
                    end else begin
                        sum        = sum + SUM_ONE;
                        angle_d[i] = angle_q[i] - ANG_ONE;
                    end
                end

                // Symmetric clamp; the most negative code is never produced.
                if (sum > SAT_HI) begin
                    pending_d[i]  = SAT_HI[PEND_W-1:0];
                    overflow_d[i] = 1'b1;
                end else if (sum < SAT_LO) begin
                    pending_d[i]  = SAT_LO[PEND_W-1:0];
                    overflow_d[i] = 1'b1;
                end else begin
                    pending_d[i]  = sum[PEND_W-1:0];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Round-robin scan over the registered pending values
    // -----------------------------------------------------------------------
    logic [CHANNELS-1:0] cand;       // channel eligible for a grant
    logic [CHANNELS-1:0] cand_pos;   // pending is positive
    logic                scan_found;
    logic [CH_W-1:0]     scan_chan;
    logic                scan_dir;

    always_comb begin
        cand       = '0;
        cand_pos   = '0;
        scan_found = 1'b0;
        scan_chan  = '0;
        scan_dir   = 1'b0;
        for (int j = 0; j < CHANNELS; j++) begin
            cand[j]     = (pending_q[j] != '0) && !zero[j];
            cand_pos[j] = !pending_q[j][PEND_W-1];
        end
        // Offset k = 1 is the channel right after the last grant; the first
        // eligible offset wins. Only one j matches a given k.
        for (int k = 1; k <= CHANNELS; k++) begin
            for (int j = 0; j < CHANNELS; j++) begin
                if (!scan_found && cand[j] &&
                    ((int'(last_grant_q) + k) % CHANNELS) == j) begin
                    scan_found = 1'b1;
                    scan_chan  = CH_W'(j);
                    scan_dir   = cand_pos[j];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Request FSM
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        req_chan_d   = req_chan_q;
        req_dir_d    = req_dir_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rate_strobe && scan_found) begin
                    state_d    = ST_REQ;
                    req_chan_d = scan_chan;
                    req_dir_d  = scan_dir;
                end
            end
            ST_REQ: begin
                // Strobes are ignored here and not remembered.
                if (zero_on_req) begin
                    state_d = ST_IDLE;
                end else if (ack_take) begin
                    state_d      = ST_IDLE;
                    last_grant_d = req_chan_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLOCKH or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_chan_q   <= '0;
            req_dir_q    <= 1'b0;
            last_grant_q <= CH_W'(CHANNELS - 1);
            overflow_q   <= '0;
            // NOTE: the per-channel arrays are real state visible at the
            // outputs, so every element is reset, not left as a RAM.
            for (int i = 0; i < CHANNELS; i++) begin
                pending_q[i] <= '0;
                angle_q[i]   <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values computed by the combinational blocks.
            state_q      <= state_d;
            req_chan_q   <= req_chan_d;
            req_dir_q    <= req_dir_d;
            last_grant_q <= last_grant_d;
            overflow_q   <= overflow_d;
            for (int i = 0; i < CHANNELS; i++) begin
                pending_q[i] <= pending_d[i];
                angle_q[i]   <= angle_d[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign req_valid = (state_q == ST_REQ);
    assign req_chan  = req_chan_q;
    assign req_dir   = req_dir_q;
    assign overflow  = overflow_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_angle
        assign angle[g*ANGLE_W +: ANGLE_W] = angle_q[g];
    end

endmodule

// File: tb/tb_cdu_counter_bank.sv
// ---------------------------------------------------------------------------
// tb_cdu_counter_bank
//
// Bench for cdu_counter_bank with the default parameters. A behavioural model
// (integer pending counts, angles, overflow flags and a busy/idle request
// record) is advanced once per clock from the driven inputs; a compare
// process checks every DUT output against it on each falling edge. Directed
// scenarios add hand-computed literal expectations, then a long randomized
// phase exercises arbitration, saturation, zeroing and withdrawal.
// ---------------------------------------------------------------------------
module tb_cdu_counter_bank;

    localparam int CH   = 3;
    localparam int PW   = 6;
    localparam int AW   = 16;
    localparam int CW   = 3;
    localparam int PMAX = 31;
    localparam int AMSK = 65535;

    logic              CLOCKH = 1'b0;
    logic              rst_n  = 1'b0;
    logic [CH-1:0]     up_pulse = '0;
    logic [CH-1:0]     dn_pulse = '0;
    logic [CH-1:0]     zero     = '0;
    logic              rate_strobe = 1'b0;
    logic              req_valid;
    logic [CW-1:0]     req_chan;
    logic              req_dir;
    logic              req_ack = 1'b0;
    logic [CH*AW-1:0]  angle;
    logic [CH-1:0]     overflow;

    always #5 CLOCKH = ~CLOCKH;

    cdu_counter_bank #(
        .CHANNELS(CH), .PEND_W(PW), .ANGLE_W(AW), .CH_W(CW)
    ) dut (
        .CLOCKH     (CLOCKH),
        .rst_n      (rst_n),
        .up_pulse   (up_pulse),
        .dn_pulse   (dn_pulse),
        .zero       (zero),
        .rate_strobe(rate_strobe),
        .req_valid  (req_valid),
        .req_chan   (req_chan),
        .req_dir    (req_dir),
        .req_ack    (req_ack),
        .angle      (angle),
        .overflow   (overflow)
    );

    // ---------------- behavioural model ----------------
    int m_pend [CH];
    int m_ang  [CH];
    bit m_ovf  [CH];
    bit m_busy;
    int m_chan;
    bit m_dir;
    int m_lg;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] ang(input int i);
        return angle[i*AW +: AW];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_pend[i] = 0;
            m_ang[i]  = 0;
            m_ovf[i]  = 1'b0;
        end
        m_busy = 1'b0;
        m_chan = 0;
        m_dir  = 1'b0;
        m_lg   = CH - 1;
    endtask

    // One clock of the specification's rules, using pre-edge model state.
    task automatic model_update();
        bit acked;
        int d, v, idx;
        int np [CH];
        int na [CH];
        bit no [CH];
        acked = m_busy && req_ack && !zero[m_chan];
        for (int i = 0; i < CH; i++) begin
            if (zero[i]) begin
                np[i] = 0; na[i] = 0; no[i] = 1'b0;
            end else begin
                d = (acked && m_chan == i) ? (m_dir ? 1 : -1) : 0;
                v = m_pend[i] + int'(up_pulse[i]) - int'(dn_pulse[i]) - d;
                no[i] = m_ovf[i];
                if (v > PMAX)  begin v = PMAX;  no[i] = 1'b1; end
                if (v < -PMAX) begin v = -PMAX; no[i] = 1'b1; end
                np[i] = v;
                na[i] = (m_ang[i] + d) & AMSK;
            end
        end
        if (m_busy) begin
            if (zero[m_chan]) begin
                m_busy = 1'b0;
            end else if (acked) begin
                m_busy = 1'b0;
                m_lg   = m_chan;
            end
        end else if (rate_strobe) begin
            for (int k = 1; k <= CH; k++) begin
                idx = (m_lg + k) % CH;
                if (!m_busy && m_pend[idx] != 0 && !zero[idx]) begin
                    m_busy = 1'b1;
                    m_chan = idx;
                    m_dir  = (m_pend[idx] > 0);
                end
            end
        end
        for (int i = 0; i < CH; i++) begin
            m_pend[i] = np[i];
            m_ang[i]  = na[i];
            m_ovf[i]  = no[i];
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge CLOCKH) begin
        if (cmp_en) begin
            check("cyc_req_valid", {31'd0, req_valid}, {31'd0, m_busy});
            if (m_busy) begin
                check("cyc_req_chan", {29'd0, req_chan}, m_chan);
                check("cyc_req_dir",  {31'd0, req_dir},  {31'd0, m_dir});
            end
            for (int i = 0; i < CH; i++) begin
                check($sformatf("cyc_angle%0d", i), {16'd0, ang(i)}, m_ang[i]);
                check($sformatf("cyc_ovf%0d", i), {31'd0, overflow[i]}, {31'd0, m_ovf[i]});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic [CH-1:0] up, input logic [CH-1:0] dn,
                        input logic [CH-1:0] z, input bit s, input bit a);
        up_pulse    = up;
        dn_pulse    = dn;
        zero        = z;
        rate_strobe = s;
        req_ack     = a;
        @(posedge CLOCKH);
        if (rst_n) model_update();
        #1;
        up_pulse    = '0;
        dn_pulse    = '0;
        zero        = '0;
        rate_strobe = 1'b0;
        req_ack     = 1'b0;
    endtask

    task automatic idle();
        step('0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic strobe();
        step('0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic ack();
        step('0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge CLOCKH);
        #1;
        rst_n = 1'b1;
    endtask

    int exp_ch  [4] = '{0, 1, 2, 0};
    bit exp_dir [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int pct;

    initial begin
        model_reset();
        cmp_en = 1'b1;

        // 1: reset state, then five paced PCDU increments on ch1
        do_reset();
        check("rst_req_valid", {31'd0, req_valid}, 0);
        check("rst_req_chan",  {29'd0, req_chan},  0);
        check("rst_req_dir",   {31'd0, req_dir},   0);
        check("rst_angle",     angle[31:0],        0);
        check("rst_overflow",  {29'd0, overflow},  0);
        repeat (5) step(3'b010, '0, '0, 1'b0, 1'b0);
        for (int n = 0; n < 5; n++) begin
            strobe();
            check("t1_valid", {31'd0, req_valid}, 1);
            check("t1_chan",  {29'd0, req_chan},  1);
            check("t1_dir",   {31'd0, req_dir},   1);
            idle();
            idle();
            ack();
            check("t1_valid_drop", {31'd0, req_valid}, 0);
        end
        check("t1_angle1", {16'd0, ang(1)}, 5);
        strobe();
        check("t1_drained", {31'd0, req_valid}, 0);

        // 2: round-robin order with mixed directions
        do_reset();
        step(3'b101, 3'b010, '0, 1'b0, 1'b0);
        step(3'b001, '0, '0, 1'b0, 1'b0);
        for (int n = 0; n < 4; n++) begin
            strobe();
            check("t2_valid", {31'd0, req_valid}, 1);
            check($sformatf("t2_chan%0d", n), {29'd0, req_chan}, exp_ch[n]);
            check($sformatf("t2_dir%0d", n),  {31'd0, req_dir},  {31'd0, exp_dir[n]});
            ack();
        end
        check("t2_angle0", {16'd0, ang(0)}, 2);
        check("t2_angle1", {16'd0, ang(1)}, 32'hFFFF);
        check("t2_angle2", {16'd0, ang(2)}, 1);

        // 3: saturation at +31, sticky overflow, zero clears
        do_reset();
        repeat (40) step(3'b100, '0, '0, 1'b0, 1'b0);
        check("t3_ovf_set", {31'd0, overflow[2]}, 1);
        for (int n = 0; n < 31; n++) begin
            strobe();
            check("t3_chan", {29'd0, req_chan}, 2);
            ack();
        end
        check("t3_angle_sat", {16'd0, ang(2)}, 31);
        strobe();
        check("t3_empty", {31'd0, req_valid}, 0);
        check("t3_ovf_sticky", {31'd0, overflow[2]}, 1);
        repeat (3) step(3'b100, '0, '0, 1'b0, 1'b0);
        step('0, '0, 3'b100, 1'b0, 1'b0);
        check("t3_ovf_zeroed", {31'd0, overflow[2]}, 0);
        check("t3_angle_zeroed", {16'd0, ang(2)}, 0);
        strobe();
        check("t3_pend_zeroed", {31'd0, req_valid}, 0);

        // 4: angle wrap in both directions
        do_reset();
        step('0, 3'b001, '0, 1'b0, 1'b0);
        strobe();
        check("t4_dir_m", {31'd0, req_dir}, 0);
        ack();
        check("t4_wrap_down", {16'd0, ang(0)}, 32'hFFFF);
        step(3'b001, '0, '0, 1'b0, 1'b0);
        strobe();
        check("t4_dir_p", {31'd0, req_dir}, 1);
        ack();
        check("t4_wrap_up", {16'd0, ang(0)}, 0);

        // 5: zero withdraws an in-flight request, ack in the same cycle ignored
        do_reset();
        step(3'b110, '0, '0, 1'b0, 1'b0);
        step(3'b010, '0, '0, 1'b0, 1'b0);
        strobe();
        check("t5_chan1", {29'd0, req_chan}, 1);
        step('0, '0, 3'b010, 1'b0, 1'b1);
        check("t5_withdrawn", {31'd0, req_valid}, 0);
        check("t5_angle1", {16'd0, ang(1)}, 0);
        strobe();
        check("t5_valid", {31'd0, req_valid}, 1);
        check("t5_chan2", {29'd0, req_chan}, 2);
        ack();

        // 6: cancelling pulses, strobes during REQ are not queued
        do_reset();
        step(3'b001, '0, '0, 1'b0, 1'b0);
        step(3'b001, 3'b001, '0, 1'b0, 1'b0);
        strobe();
        check("t6_chan0", {29'd0, req_chan}, 0);
        repeat (4) strobe();
        check("t6_held", {31'd0, req_valid}, 1);
        ack();
        check("t6_drop", {31'd0, req_valid}, 0);
        repeat (3) idle();
        check("t6_no_queue", {31'd0, req_valid}, 0);
        strobe();
        check("t6_cancelled", {31'd0, req_valid}, 0);

        // 7: randomized traffic against the model
        do_reset();
        for (int n = 0; n < 6000; n++) begin
            logic [CH-1:0] u, d, z;
            bit s, a;
            pct = (n < 3000) ? 30 : 6;
            for (int i = 0; i < CH; i++) begin
                u[i] = ($urandom_range(0, 99) < pct);
                d[i] = ($urandom_range(0, 99) < pct);
                z[i] = ($urandom_range(0, 99) < 2);
            end
            s = ($urandom_range(0, 99) < 25);
            a = m_busy ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 99) < 5);
            step(u, d, z, s, a);
        end

        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
